sram_port_arbiter: RTL and testbench

//  Shares the single external 16-bit SRAM between two requesters: port 0 (audio DSP record/play

---
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single asynchronous 16-bit SRAM. Port 0 has priority;
// port 1 gets a forced grant after STARVE_LIMIT consecutive port-0 wins while it waits.
module sram_port_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_p0_req,
   input  logic              i_p0_we,
   input  logic [ADDR_W-1:0] i_p0_addr,
   input  logic [DATA_W-1:0] i_p0_wdata,
   output logic              o_p0_ack,
   output logic [DATA_W-1:0] o_p0_rdata,
   input  logic              i_p1_req,
   input  logic              i_p1_we,
   input  logic [ADDR_W-1:0] i_p1_addr,
   input  logic [DATA_W-1:0] i_p1_wdata,
   output logic              o_p1_ack,
   output logic [DATA_W-1:0] o_p1_rdata,
   output logic              o_busy,
   output logic              o_owner,
   output logic [1:0]        o_dbg_state,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N
);

   // Handshake: a requester raises req with stable we/addr/wdata and holds them until its
   // one-cycle ack; fields are captured only at grant, and dropping req before grant withdraws it.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cyc_q, cyc_d;
   logic [STV_W-1:0]    starve_q, starve_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

   logic                any_req;
   logic                grant_port;
   logic                in_access;

   always_comb begin
      any_req    = i_p0_req | i_p1_req;
      grant_port = 1'b0;
      if (i_p1_req && (!i_p0_req || (starve_q == STV_MAX))) begin
         grant_port = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         cyc_q      <= '0;
         starve_q   <= '0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         starve_q   <= starve_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      starve_d   = starve_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (!i_p1_req) begin
               starve_d = '0;
            end
            if (any_req) begin
               state_d = S_ACCESS;
               cyc_d   = '0;
               owner_d = grant_port;
               if (grant_port) begin
                  we_d     = i_p1_we;
                  addr_d   = i_p1_addr;
                  wdata_d  = i_p1_wdata;
                  starve_d = '0;
               end else begin
                  we_d    = i_p0_we;
                  addr_d  = i_p0_addr;
                  wdata_d = i_p0_wdata;
                  // Only a port-0 win over a waiting port 1 counts toward forcing port 1.
                  if (i_p1_req && (starve_q != STV_MAX)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (cyc_q == CYC_LAST) begin
               state_d = S_ACK;
               if (!we_q) begin
                  if (owner_q) begin
                     p1_rdata_d = io_SRAM_DQ;
                  end else begin
                     p0_rdata_d = io_SRAM_DQ;
                  end
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // S_ACK releases every strobe and the data bus, giving a turnaround cycle between accesses.
   assign in_access   = (state_q == S_ACCESS);
   assign o_SRAM_CE_N = ~in_access;
   assign o_SRAM_LB_N = ~in_access;
   assign o_SRAM_UB_N = ~in_access;
   assign o_SRAM_OE_N = ~(in_access & ~we_q);
   assign o_SRAM_WE_N = ~(in_access & we_q);
   assign io_SRAM_DQ  = (in_access && we_q) ? wdata_q : {DATA_W{1'bz}};
   assign o_SRAM_ADDR = addr_q;

   assign o_p0_ack    = (state_q == S_ACK) && !owner_q;
   assign o_p1_ack    = (state_q == S_ACK) && owner_q;
   assign o_p0_rdata  = p0_rdata_q;
   assign o_p1_rdata  = p1_rdata_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_owner     = owner_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural SRAM on the pins.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [19:0] p0_addr = '0;
   logic [15:0] p0_wdata = '0;
   logic        p0_ack;
   logic [15:0] p0_rdata;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [19:0] p1_addr = '0;
   logic [15:0] p1_wdata = '0;
   logic        p1_ack;
   logic [15:0] p1_rdata;
   logic        busy, owner;
   logic [1:0]  dbg_state;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        we_n, ce_n, oe_n, lb_n, ub_n;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
      .o_p0_ack(p0_ack), .o_p0_rdata(p0_rdata),
      .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
      .o_p1_ack(p1_ack), .o_p1_rdata(p1_rdata),
      .o_busy(busy), .o_owner(owner), .o_dbg_state(dbg_state),
      .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
      .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
      .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
   );

   // SRAM model: 256 words on addr[7:0]; drives DQ while read-enabled, writes on clock edges with WE_N low.
   logic [15:0] mem [0:255];
   logic        model_drive;
   assign model_drive = !ce_n && !oe_n && we_n;
   assign sram_dq = model_drive ? mem[sram_addr[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h10] <= 16'hBEEF;
      end else if (!ce_n && !we_n) begin
         mem[sram_addr[7:0]] <= sram_dq;
      end
   end

   function automatic logic [4:0] strobes();
      return {we_n, ce_n, oe_n, lb_n, ub_n};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_ack(output int n, output logic [1:0] who);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(p0_ack || p1_ack) && n < 20);
      who = {p1_ack, p0_ack};
   endtask

   int          n;
   logic [1:0]  who;
   logic        seen;
   logic [9:0]  seq;

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_p0_ack", p0_ack, 0);
      chk("rst_p1_ack", p1_ack, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_strobes", strobes(), 5'b11111);
      chk("rst_state", dbg_state, 0);
      rst = 1'b0;
      step();

      // 1: port-0 read of 0x00010 (model holds 0xBEEF)
      p0_we = 1'b0; p0_addr = 20'h00010; p0_req = 1'b1;
      step();
      chk("t1_strobes_c1", strobes(), 5'b10000);
      chk("t1_busy", busy, 1);
      chk("t1_addr", sram_addr, 20'h00010);
      chk("t1_dq", sram_dq, 16'hBEEF);
      chk("t1_ack_c1", p0_ack, 0);
      step();
      chk("t1_strobes_c2", strobes(), 5'b10000);
      chk("t1_ack_c2", p0_ack, 0);
      step();
      chk("t1_ack", p0_ack, 1);
      chk("t1_p1_ack", p1_ack, 0);
      chk("t1_rdata", p0_rdata, 16'hBEEF);
      chk("t1_strobes_ack", strobes(), 5'b11111);
      p0_req = 1'b0;
      step();

      // 2: port-1 write 0x12345 <- 0xA5A5, then read back
      p1_we = 1'b1; p1_addr = 20'h12345; p1_wdata = 16'hA5A5; p1_req = 1'b1;
      step();
      chk("t2_strobes_c1", strobes(), 5'b00100);
      chk("t2_dq_c1", sram_dq, 16'hA5A5);
      chk("t2_owner", owner, 1);
      chk("t2_addr", sram_addr, 20'h12345);
      step();
      chk("t2_strobes_c2", strobes(), 5'b00100);
      chk("t2_dq_c2", sram_dq, 16'hA5A5);
      step();
      chk("t2_wr_ack", p1_ack, 1);
      chk("t2_wr_p0_ack", p0_ack, 0);
      chk("t2_wr_rdata", p1_rdata, 0);
      chk("t2_strobes_ack", strobes(), 5'b11111);
      p1_we = 1'b0;
      wait_ack(n, who);
      chk("t2_rd_lat", n, 4);
      chk("t2_rd_who", who, 2'b10);
      chk("t2_rd_rdata", p1_rdata, 16'hA5A5);
      chk("t2_p0_rdata", p0_rdata, 16'hBEEF);
      p1_req = 1'b0;

      // 3: both requesting, port 0 held: P0 x4 then P1, twice
      p0_we = 1'b0; p0_addr = 20'h00010; p0_req = 1'b1;
      p1_we = 1'b0; p1_addr = 20'h12345; p1_req = 1'b1;
      seq = 10'b10000_10000;
      for (int i = 0; i < 10; i++) begin
         wait_ack(n, who);
         chk($sformatf("t3_grant%0d", i), who, seq[i] ? 2'b10 : 2'b01);
      end
      chk("t3_p1_rdata", p1_rdata, 16'hA5A5);
      p0_req = 1'b0; p1_req = 1'b0;
      step();

      // 4: port 1 withdraws while port 0 is in its third access
      p0_req = 1'b1; p1_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wait_ack(n, who);
         chk($sformatf("t4_grant%0d", i), who, 2'b01);
      end
      step();
      step();
      chk("t4_busy", busy, 1);
      chk("t4_owner", owner, 0);
      p1_req = 1'b0;
      wait_ack(n, who);
      chk("t4_grant2", who, 2'b01);
      p0_req = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         step();
         seen = seen | p1_ack;
      end
      chk("t4_no_p1_ack", seen, 0);
      chk("t4_idle", busy, 0);
      p0_req = 1'b1; p1_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_ack(n, who);
         chk($sformatf("t4_regrant%0d", i), who, (i == 4) ? 2'b10 : 2'b01);
      end
      p0_req = 1'b0; p1_req = 1'b0;
      step();

      // 5: reset during a write access, then the held request completes
      p0_we = 1'b1; p0_addr = 20'h00022; p0_wdata = 16'h1111; p0_req = 1'b1;
      step();
      chk("t5_strobes_wr", strobes(), 5'b00100);
      rst = 1'b1;
      #1;
      chk("t5_strobes_rst", strobes(), 5'b11111);
      chk("t5_busy_rst", busy, 0);
      chk("t5_ack_rst", p0_ack, 0);
      chk("t5_state_rst", dbg_state, 0);
      chk("t5_rdata_rst", p0_rdata, 0);
      step();
      chk("t5_ack_held", p0_ack, 0);
      rst = 1'b0;
      wait_ack(n, who);
      chk("t5_wr_lat", n, 3);
      chk("t5_wr_who", who, 2'b01);
      p0_we = 1'b0;
      wait_ack(n, who);
      chk("t5_rd_lat", n, 4);
      chk("t5_rd_rdata", p0_rdata, 16'h1111);
      p0_req = 1'b0;
      step();

      // 6: held request, acks spaced ACCESS_CYCLES+2
      p0_addr = 20'h00010; p0_req = 1'b1;
      wait_ack(n, who);
      chk("t6_lat0", n, 3);
      wait_ack(n, who);
      chk("t6_gap1", n, 4);
      wait_ack(n, who);
      chk("t6_gap2", n, 4);
      chk("t6_rdata", p0_rdata, 16'hBEEF);
      p0_req = 1'b0;
      step();
      step();
      chk("t6_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
